// File: rtl/add_int_mw_seq.sv
// Multi-word sequential adder/subtractor: one 32-bit CLA
// reused per word, carry rippled between words in a register.

// 32-bit carry-lookahead adder built from 4-bit groups with
// block propagate/generate outputs for the word-level carry.
module add_int_mw_cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        pm,
    output logic        gm
);

    logic [31:0] p;
    logic [31:0] g;
    logic [31:0] c;
    logic [7:0]  gp;
    logic [7:0]  gg;
    logic [8:0]  gc;
    logic        blk_g;

    // Bit propagate/generate and 4-bit group terms
    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gp = '0;
        gg = '0;
        for (int k = 0; k < 8; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Group carries, then bit carries inside each group
    always_comb begin
        gc    = '0;
        c     = '0;
        blk_g = 1'b0;
        gc[0] = cin;
        for (int k = 0; k < 8; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
            blk_g   = gg[k] | (gp[k] & blk_g);
        end
        for (int k = 0; k < 8; k++) begin
            c[4*k] = gc[k];
            for (int i = 0; i < 3; i++) begin
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
            end
        end
    end

    assign sum = p ^ c;
    assign pm  = &p;
    assign gm  = blk_g;

endmodule

module add_int_mw_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   s,
    output logic                  cout,
    output logic                  ovf
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WORDS-1:0][31:0] a_q;
    logic [WORDS-1:0][31:0] b_q;
    logic [WORDS-1:0][31:0] s_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   carry_q;
    logic                   cout_q;
    logic                   ovf_q;

    logic [31:0] word_a;
    logic [31:0] word_b;
    logic [31:0] word_s;
    logic        word_pm;
    logic        word_gm;
    logic        carry_nx;
    logic        last;
    logic        accept;

    assign word_a   = a_q[idx_q];
    assign word_b   = b_q[idx_q];
    assign carry_nx = word_gm | (word_pm & carry_q);
    assign last     = (idx_q == IDX_W'(WORDS-1));
    assign accept   = (state_q == IDLE) & in_valid;

    add_int_mw_cla32 u_cla (
        .a   (word_a),
        .b   (word_b),
        .cin (carry_q),
        .sum (word_s),
        .pm  (word_pm),
        .gm  (word_gm)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = RUN;
            RUN:  if (last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, per-word sum, carry ripple and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            s_q[idx_q] <= word_s;
            carry_q    <= carry_nx;
            idx_q      <= idx_q + 1'b1;
            if (last) begin
                cout_q <= carry_nx;
                ovf_q  <= (word_a[31] == word_b[31])
                        & (word_s[31] != word_a[31]);
            end
        end
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_int_mw_seq.sv
// Directed-table and random checks for the multi-word
// sequential adder/subtractor with WORDS = 4.

module tb_add_int_mw_seq;

    localparam int WORDS = 4;
    localparam int W = 32 * WORDS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int checks;
    int errors;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[10];

    add_int_mw_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts, input int stall,
                          output logic [W-1:0] rs, output logic rc,
                          output logic ro, output int lat);
        int n;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; sub = ts;
        in_valid = 1'b1;
        out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        rs = '0; rc = 1'b0; ro = 1'b0; lat = -1;
        if (!in_ready) begin
            chk("accept_timeout", 128'(in_ready), 128'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        cin = 1'($urandom);
        sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            chk("done_timeout", 128'(out_valid), 128'(1));
            return;
        end
        rs = s; rc = cout; ro = ovf;
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            chk("stall_hold", {s[W-3:0], cout, ovf}, {rs[W-3:0], rc, ro});
            chk("stall_valid", 128'(out_valid), 128'(1));
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("after_handshake", 128'(out_valid), 128'(0));
    endtask

    initial begin
        logic [W-1:0] rs;
        logic [W-1:0] snap_s;
        logic [W-1:0] beff;
        logic [W:0]   ref_sum;
        logic         rc;
        logic         ro;
        logic         snap_c;
        logic         snap_o;
        logic         exp_o;
        int           lat;
        int           n;

        checks = 0;
        errors = 0;

        vecs[0] = '{{W{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0};
        vecs[1] = '{128'd5, 128'd7, 1'b0, 1'b1,
                    {{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0};
        vecs[2] = '{{1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, 1'b0,
                    {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1};
        vecs[3] = '{128'd0, 128'd0, 1'b1, 1'b0, 128'd1, 1'b0, 1'b0};
        vecs[4] = '{{1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}},
                    1'b0, 1'b0, 128'd0, 1'b1, 1'b1};
        vecs[5] = '{128'd0, 128'd1, 1'b0, 1'b1, {W{1'b1}}, 1'b0, 1'b0};
        vecs[6] = '{{1'b1, {(W-1){1'b0}}}, 128'd1, 1'b0, 1'b1,
                    {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1};
        vecs[7] = '{128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd0,
                    1'b1, 1'b0,
                    128'h0000_0000_0000_0001_0000_0000_0000_0000,
                    1'b0, 1'b0};
        vecs[8] = '{128'd10, 128'd3, 1'b1, 1'b1, 128'd7, 1'b1, 1'b0};
        vecs[9] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                    128'h1111_1111_1111_1111_1111_1111_1111_1111,
                    1'b0, 1'b0,
                    128'h1234_5678_9ABC_DF01_0FED_CBA9_8765_4321,
                    1'b0, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'(0));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_s", s, 128'd0);
        chk("reset_flags", 128'({cout, ovf}), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_in_ready", 128'(in_ready), 128'(1));

        // Directed table, alternating early out_ready and stalls
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   (i % 3 == 1) ? 3 : 0, rs, rc, ro, lat);
            chk($sformatf("vec%0d_s", i), rs, vecs[i].s);
            chk($sformatf("vec%0d_cout", i), 128'(rc), 128'(vecs[i].cout));
            chk($sformatf("vec%0d_ovf", i), 128'(ro), 128'(vecs[i].ovf));
            chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(WORDS));
        end

        // Backpressure with a new request waiting in DONE
        @(negedge clk);
        a = vecs[2].a; b = vecs[2].b; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        a = 128'd5; b = 128'd3; cin = 1'b0; sub = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_lat", 128'(n), 128'(WORDS));
        snap_s = s; snap_c = cout; snap_o = ovf;
        chk("bp_result", s, vecs[2].s);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_s", s, snap_s);
            chk("bp_hold_flags", 128'({cout, ovf}), 128'({snap_c, snap_o}));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_idle_valid", 128'(out_valid), 128'(0));
        chk("bp_idle_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accepted", 128'(in_ready), 128'(0));
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_next_lat", 128'(n), 128'(WORDS));
        chk("bp_next_s", s, 128'd8);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset two cycles into RUN
        @(negedge clk);
        a = vecs[9].a; b = vecs[9].b; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_s", s, 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_flags", 128'({cout, ovf}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 128'(in_ready), 128'(1));
        run_op(vecs[9].a, vecs[9].b, 1'b0, 1'b0, 0, rs, rc, ro, lat);
        chk("rst_next_s", rs, vecs[9].s);
        chk("rst_next_lat", 128'(lat), 128'(WORDS));

        // Random regression against a 129-bit reference
        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rci;
            logic         rsub;
            int           st;
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rci = 1'($urandom);
            rsub = 1'($urandom);
            st = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            beff = rsub ? ~rb : rb;
            ref_sum = {1'b0, ra} + {1'b0, beff} + (W+1)'(rsub ? 1'b1 : rci);
            exp_o = (ra[W-1] == beff[W-1]) & (ref_sum[W-1] != ra[W-1]);
            run_op(ra, rb, rci, rsub, st, rs, rc, ro, lat);
            chk("rand_result", {rs[W-3:0], rc, ro},
                {ref_sum[W-3:0], ref_sum[W], exp_o});
            if (rs[W-1:W-2] !== ref_sum[W-1:W-2])
                chk("rand_s_top", 128'(rs[W-1:W-2]), 128'(ref_sum[W-1:W-2]));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/add_int_mw_seq.md
# add_int_mw_seq

Multi-word sequential integer adder/subtractor that widens the 32-bit carry-lookahead adder to operands of `32*WORDS` bits. It is the stage directly upstream of the 32-bit CLA. It latches a wide operand pair, drives one 32-bit word per cycle into a single internal CLA instance, and ripples the carry between words through a register. It also consumes the CLA's block propagate/generate outputs to form that carry. Operands arrive and results leave on valid/ready handshakes.

## Interface
- `WORDS`, default 4: number of 32-bit words per operand; legal values are 1 to 64.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: the operand set on `a`, `b`, `cin` and `sub` is valid.
- `in_ready`, output, 1: the block can accept operands.
- `a`, input, 32*WORDS: operand A.
- `b`, input, 32*WORDS: operand B.
- `cin`, input, 1: carry-in for addition; ignored when `sub` = 1.
- `sub`, input, 1: 1 selects A − B, computed as A + ~B + 1.
- `out_valid`, output, 1: the result is valid.
- `out_ready`, input, 1: the consumer accepts the result.
- `s`, output, 32*WORDS: sum or difference.
- `cout`, output, 1: carry out of the top word. For subtraction, 1 means no borrow.
- `ovf`, output, 1: two's-complement signed overflow of the full-width operation.

## Operation
- FSM states: IDLE, RUN, DONE. The reset state is IDLE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`:
    - latch `a`;
    - latch `b` as-is, or bitwise inverted when `sub` = 1;
    - set carry register to `cin`, or to 1 when `sub` = 1;
    - clear word index to 0;
    - go to RUN.
- RUN:
  - The CLA input is word `idx` of the latched A and B (bits `32*idx+31 : 32*idx`), with cin = the carry register.
  - Each cycle:
    - write the CLA sum into word `idx` of the result register;
    - set carry ← `gm | (pm & carry)`;
    - increment `idx`.
  - When `idx` = WORDS−1 is processed:
    - set `cout` ← the new carry;
    - set `ovf` ← (A[msb] == Beff[msb]) & (sum[msb] != A[msb]), where Beff is the post-inversion B;
    - go to DONE.
- DONE:
  - `out_valid` = 1.
  - `s`, `cout` and `ovf` hold stable until the handshake.
  - On `out_ready`, go to IDLE.
- Width rules:
  - Arithmetic is modulo 2^(32*WORDS).
  - The word index is `clog2(WORDS)` bits wide, minimum 1 bit.
- Reset values:
  - `in_ready` = 0 while `rst` is high. It is the IDLE decode, so it becomes 1 once reset is released.
  - `out_valid`, `s`, `cout`, `ovf` = 0.
  - Carry register and index = 0.
- Boundary conditions:
  - `in_valid` during RUN or DONE is ignored. `in_ready` is 0 there, and the upstream side must hold its operands.
  - `out_ready` held high before DONE has no effect.
  - In DONE with `out_ready` = 1, the block returns to IDLE. A new operand set cannot be accepted in the same cycle; it is accepted on the following cycle at the earliest.
  - WORDS = 1 gives a single RUN cycle.
  - Assertion of `rst` mid-RUN or in DONE aborts the operation immediately and returns all state to reset values. No partial result is presented.
  - Input changes after acceptance do not affect the result in flight.

## Timing
- Throughput: one operation per WORDS+2 cycles when the consumer is always ready.
- Latency:
  - Accept occurs at edge T.
  - RUN occupies edges T+1 through T+WORDS.
  - `out_valid` rises after edge T+WORDS.
  - Earliest `out_ready` handshake: edge T+WORDS+1.
  - Earliest next accept: edge T+WORDS+2.
- `in_ready` and `out_valid` are registered state decodes, with no combinational path from `in_valid` or `out_ready`.
- The critical path is one CLA evaluation plus the carry combine and register setup.

## Test plan
All scenarios use WORDS = 4.

1. Full carry ripple:
   - Stimulus: A = all-ones, B = 1, cin = 0, add.
   - Required response: `s` = 0, `cout` = 1, `ovf` = 0. `out_valid` asserts exactly 4 cycles after accept.
2. Subtraction with borrow:
   - Stimulus: A = 5, B = 7, sub = 1.
   - Required response: `s` = 2^128 − 2 (all-ones except bit 0 = 0), `cout` = 0, `ovf` = 0.
3. Signed overflow:
   - Stimulus: A = 0x7FFF…FFFF, B = 1, add.
   - Required response: `s` = 0x8000…0000, `ovf` = 1, `cout` = 0.
4. Backpressure:
   - Stimulus: hold `out_ready` = 0 for 10 cycles in DONE, and drive a new `in_valid` with changed operands during that time.
   - Required response: `s`, `cout` and `ovf` stay stable; `in_ready` stays 0; the new operands are accepted only after the handshake completes and the FSM has returned to IDLE.
5. Reset mid-RUN:
   - Stimulus: assert `rst` two cycles after accept.
   - Required response: `out_valid` and `s` go to 0 immediately (asynchronously). `in_ready` goes to 0 while reset is held and returns to 1 after release. The next operation is computed correctly.
6. Random regression:
   - Stimulus: 10,000 random A, B, cin and sub vectors with random `out_ready` stalls.
   - Required response: every result matches a 129-bit reference model for `s` and `cout`, plus the signed-overflow rule above for `ovf`.
